// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the HI/LO multiply/divide sequencer.
// Holds the op_type encodings, the FSM state type and the default parameters.
package muldiv_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 48;
    localparam int unsigned OP_W_DEFAULT    = 3;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUSY_MUL,
        ST_BUSY_DIV,
        ST_DONE,
        ST_COOL
    } state_t;

    // How a multiply result is merged into {hi,lo} on completion.
    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_ADD,
        ACC_SUB
    } acc_t;

endpackage

// File: rtl/muldiv_watchdog.sv
// muldiv_watchdog: cycle counter bounding how long an iterative unit may run.
// Cleared while the controller is idle, counts while enabled, and raises
// o_expire during the LIMIT-th enabled cycle.
module muldiv_watchdog
    import muldiv_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_count;

    // Count enabled cycles; clear has priority, saturate once expired.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !o_expire) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expire in the cycle where LIMIT enabled cycles have elapsed.
    always_comb begin
        o_expire = i_en && (r_count == CW'(LIMIT - 1));
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer between execute and the iterative mul/div units.
// Owns HI/LO, decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO and stalls the pipe while
// a unit runs. Define MULDIV_MADD_EN to enable MADD/MSUB accumulation
// (op_type 6/7); otherwise those encodings are no-ops.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned OP_W    = OP_W_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            op_valid,
    input  logic [OP_W-1:0] op_type,
    input  logic [31:0]     op_a,
    input  logic [31:0]     op_b,
    input  logic            flush,
    output logic            stall,
    output logic [31:0]     hi,
    output logic [31:0]     lo,
    output logic            mul_begin,
    output logic            mul_unsigned,
    output logic [31:0]     mul_op1,
    output logic [31:0]     mul_op2,
    input  logic [63:0]     mul_product,
    input  logic            mul_end,
    output logic            div_begin,
    output logic            div_unsigned,
    output logic [31:0]     div_op1,
    output logic [31:0]     div_op2,
    input  logic [31:0]     div_quot,
    input  logic [31:0]     div_rem,
    input  logic            div_end,
    output logic            timeout_err
);

    state_t      r_state;
    logic [2:0]  w_op;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_is_acc;
    logic        w_is_mthi;
    logic        w_is_mtlo;
    logic        w_busy;
    logic        w_expire;
    logic [63:0] w_mul_result;
`ifdef MULDIV_MADD_EN
    acc_t        r_acc;
`endif

    // Decode the presented instruction class.
    always_comb begin
        w_op      = 3'(op_type);
        w_is_mul  = op_valid && ((w_op == OP_MULT) || (w_op == OP_MULTU));
        w_is_div  = op_valid && ((w_op == OP_DIV) || (w_op == OP_DIVU));
        w_is_mthi = op_valid && (w_op == OP_MTHI);
        w_is_mtlo = op_valid && (w_op == OP_MTLO);
`ifdef MULDIV_MADD_EN
        w_is_acc  = op_valid && ((w_op == OP_MADD) || (w_op == OP_MSUB));
`else
        w_is_acc  = 1'b0;
`endif
        w_busy    = (r_state == ST_BUSY_MUL) || (r_state == ST_BUSY_DIV);
    end

    // Value written to {hi,lo} when the multiplier completes.
    always_comb begin
        w_mul_result = mul_product;
`ifdef MULDIV_MADD_EN
        if (r_acc == ACC_ADD) begin
            w_mul_result = {hi, lo} + mul_product;
        end else if (r_acc == ACC_SUB) begin
            w_mul_result = {hi, lo} - mul_product;
        end
`endif
    end

    // Pipeline hold: raised in the accept cycle and for the whole busy span.
    always_comb begin
        stall = 1'b0;
        unique case (r_state)
            ST_IDLE:     stall = w_is_mul || w_is_div || w_is_acc;
            ST_BUSY_MUL: stall = 1'b1;
            ST_BUSY_DIV: stall = 1'b1;
            ST_DONE:     stall = 1'b0;
            ST_COOL:     stall = op_valid;
            default:     stall = 1'b0;
        endcase
    end

    muldiv_watchdog #(
        .LIMIT (TIMEOUT)
    ) u_watchdog (
        .i_clk    (clk),
        .i_rst    (reset),
        .i_clr    (r_state == ST_IDLE),
        .i_en     (w_busy),
        .o_expire (w_expire)
    );

    // Sequencing FSM with HI/LO and operand latches; flush overrides all.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            hi           <= '0;
            lo           <= '0;
            mul_begin    <= 1'b0;
            mul_unsigned <= 1'b0;
            mul_op1      <= '0;
            mul_op2      <= '0;
            div_begin    <= 1'b0;
            div_unsigned <= 1'b0;
            div_op1      <= '0;
            div_op2      <= '0;
            timeout_err  <= 1'b0;
`ifdef MULDIV_MADD_EN
            r_acc        <= ACC_NONE;
`endif
        end else begin
            timeout_err <= 1'b0;
            if (flush) begin
                r_state   <= ST_COOL;
                mul_begin <= 1'b0;
                div_begin <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_is_mul || w_is_acc) begin
                            r_state      <= ST_BUSY_MUL;
                            mul_begin    <= 1'b1;
                            mul_unsigned <= (w_op == OP_MULTU);
                            mul_op1      <= op_a;
                            mul_op2      <= op_b;
`ifdef MULDIV_MADD_EN
                            r_acc        <= (w_op == OP_MADD) ? ACC_ADD :
                                            (w_op == OP_MSUB) ? ACC_SUB : ACC_NONE;
`endif
                        end else if (w_is_div) begin
                            // Zero divisor never reaches the divider.
                            if (op_b == '0) begin
                                r_state <= ST_DONE;
                            end else begin
                                r_state      <= ST_BUSY_DIV;
                                div_begin    <= 1'b1;
                                div_unsigned <= (w_op == OP_DIVU);
                                div_op1      <= op_a;
                                div_op2      <= op_b;
                            end
                        end else if (w_is_mthi) begin
                            hi <= op_a;
                        end else if (w_is_mtlo) begin
                            lo <= op_a;
                        end
                    end
                    ST_BUSY_MUL: begin
                        if (mul_end) begin
                            {hi, lo}  <= w_mul_result;
                            mul_begin <= 1'b0;
                            r_state   <= ST_DONE;
                        end else if (w_expire) begin
                            mul_begin   <= 1'b0;
                            timeout_err <= 1'b1;
                            r_state     <= ST_COOL;
                        end
                    end
                    ST_BUSY_DIV: begin
                        if (div_end) begin
                            lo        <= div_quot;
                            hi        <= div_rem;
                            div_begin <= 1'b0;
                            r_state   <= ST_DONE;
                        end else if (w_expire) begin
                            div_begin   <= 1'b0;
                            timeout_err <= 1'b1;
                            r_state     <= ST_COOL;
                        end
                    end
                    ST_DONE: r_state <= ST_IDLE;
                    ST_COOL: r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
